// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU divide unit.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 32;

  // Quotient returned for a zero divisor.
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_abs.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fixup.
module div_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] iVal,
  input  logic             iNeg,
  output logic [WIDTH-1:0] oVal
);

  assign oVal = iNeg ? (~iVal + 1'b1) : iVal;

endmodule

// File: rtl/alu_div.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU) with start/ready/valid handshake.
// Divide-by-zero and signed overflow skip the iterations, taking one CALC cycle.
module alu_div
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic             iKill,
  input  logic             iSigned,
  input  logic [WIDTH-1:0] iX,
  input  logic [WIDTH-1:0] iY,
  output logic             oReady,
  output logic             oValid,
  output logic [WIDTH-1:0] oQ,
  output logic [WIDTH-1:0] oR,
  output logic             oDivZero,
  output logic             oOverflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] LP_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LP_ZERO_Q  = {WIDTH{DIV_ZERO_Q[0]}};

  div_state_t       r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quo, r_rem, r_div;
  logic             r_qneg, r_rneg, r_fast, r_dz_pend, r_ov_pend;

  logic             w_accept, w_xneg, w_yneg, w_dz, w_ov;
  logic [WIDTH-1:0] w_xabs, w_yabs;
  logic [WIDTH:0]   w_rem_sh, w_trial;
  logic [WIDTH-1:0] w_quo_step, w_rem_step, w_quo_pre, w_rem_pre, w_qfix, w_rfix;

  assign oReady   = (r_state == IDLE) | (r_state == DONE);
  assign oValid   = (r_state == DONE);
  assign w_accept = iStart & oReady & ~iKill;

  assign w_xneg = iSigned & iX[WIDTH-1];
  assign w_yneg = iSigned & iY[WIDTH-1];
  assign w_dz   = (iY == '0);
  assign w_ov   = iSigned & (iX == LP_MIN_NEG) & (iY == '1);

  div_abs #(.WIDTH(WIDTH)) u_x_abs (.iVal(iX), .iNeg(w_xneg), .oVal(w_xabs));
  div_abs #(.WIDTH(WIDTH)) u_y_abs (.iVal(iY), .iNeg(w_yneg), .oVal(w_yabs));

  // One restoring step; the sign of the WIDTH+1-bit trial decides the quotient bit.
  assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_trial    = w_rem_sh - {1'b0, r_div};
  assign w_rem_step = w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_step = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};

  assign w_quo_pre = r_fast ? r_quo : w_quo_step;
  assign w_rem_pre = r_fast ? r_rem : w_rem_step;

  div_abs #(.WIDTH(WIDTH)) u_q_fix (.iVal(w_quo_pre), .iNeg(r_qneg), .oVal(w_qfix));
  div_abs #(.WIDTH(WIDTH)) u_r_fix (.iVal(w_rem_pre), .iNeg(r_rneg), .oVal(w_rfix));

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = CALC;
      CALC:    if (iKill) w_next = IDLE;
               else if (r_cnt == '0) w_next = DONE;
      DONE:    w_next = w_accept ? CALC : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: the datapath is plain registers, so resetting all of it is cheap and keeps outputs defined.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_cnt     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_div     <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_fast    <= 1'b0;
      r_dz_pend <= 1'b0;
      r_ov_pend <= 1'b0;
      oQ        <= '0;
      oR        <= '0;
      oDivZero  <= 1'b0;
      oOverflow <= 1'b0;
    end else if (w_accept) begin
      oDivZero  <= 1'b0;
      oOverflow <= 1'b0;
      r_fast    <= w_dz | w_ov;
      r_dz_pend <= w_dz;
      r_ov_pend <= w_ov & ~w_dz;
      r_div     <= w_yabs;
      if (w_dz) begin
        r_cnt  <= '0;
        r_quo  <= LP_ZERO_Q;
        r_rem  <= iX;
        r_qneg <= 1'b0;
        r_rneg <= 1'b0;
      end else if (w_ov) begin
        r_cnt  <= '0;
        r_quo  <= iX;
        r_rem  <= '0;
        r_qneg <= 1'b0;
        r_rneg <= 1'b0;
      end else begin
        r_cnt  <= CW'(WIDTH - 1);
        r_quo  <= w_xabs;
        r_rem  <= '0;
        r_qneg <= w_xneg ^ w_yneg;
        r_rneg <= w_xneg;
      end
    end else if ((r_state == CALC) && !iKill) begin
      r_quo <= w_quo_step;
      r_rem <= w_rem_step;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        oQ        <= w_qfix;
        oR        <= w_rfix;
        oDivZero  <= r_dz_pend;
        oOverflow <= r_ov_pend;
      end
    end
  end

endmodule

// File: tb/tb_alu_div.sv
// Self-checking bench for alu_div: directed corner cases plus random operations against an arithmetic model.
module tb_alu_div;
  import alu_pkg::*;

  localparam int W = 32;

  logic         iClk = 1'b0;
  logic         iRst, iStart, iKill, iSigned;
  logic [W-1:0] iX, iY;
  logic         oReady, oValid, oDivZero, oOverflow;
  logic [W-1:0] oQ, oR;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  alu_div #(.WIDTH(W)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iKill(iKill), .iSigned(iSigned),
    .iX(iX), .iY(iY), .oReady(oReady), .oValid(oValid), .oQ(oQ), .oR(oR),
    .oDivZero(oDivZero), .oOverflow(oOverflow)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RISC-V divide semantics from plain arithmetic.
  task automatic ref_div(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output logic ov, output int lat);
    longint sx, sy, q64, r64;
    dz = 1'b0; ov = 1'b0; lat = W;
    if (y == 0) begin
      q = '1; r = x; dz = 1'b1; lat = 1;
    end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = x; r = '0; ov = 1'b1; lat = 1;
    end else if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q64 = sx / sy;
      r64 = sx % sy;
      q = q64[W-1:0];
      r = r64[W-1:0];
    end else begin
      q = x / y; r = x % y;
    end
  endtask

  // Drives a request now; returns 1ns after the accepting edge.
  task automatic start_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    iSigned = s; iX = x; iY = y; iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
  endtask

  // Waits for oValid; optionally pulses a stray iStart at cycle poke_at while busy.
  task automatic wait_result(input string tag, input logic s, input logic [W-1:0] x,
                             input logic [W-1:0] y, input int poke_at);
    logic [W-1:0] q, r;
    logic dz, ov;
    int lat, cnt;
    ref_div(s, x, y, q, r, dz, ov, lat);
    cnt = 0;
    while (!oValid && cnt < 40) begin
      if (cnt == poke_at) begin
        iStart = 1'b1; iSigned = 1'b0; iX = 32'd77; iY = 32'd0;
      end else begin
        iStart = 1'b0;
      end
      @(posedge iClk); #1;
      cnt++;
    end
    iStart = 1'b0;
    check({tag, "_lat"}, 64'(cnt), 64'(lat));
    check({tag, "_q"}, 64'(oQ), 64'(q));
    check({tag, "_r"}, 64'(oR), 64'(r));
    check({tag, "_flags"}, {62'd0, oDivZero, oOverflow}, {62'd0, dz, ov});
    last_q = q; last_r = r;
  endtask

  task automatic run_op(input string tag, input logic s, input logic [W-1:0] x,
                        input logic [W-1:0] y);
    @(negedge iClk);
    start_op(s, x, y);
    wait_result(tag, s, x, y, -1);
    @(posedge iClk); #1;
    check({tag, "_pulse"}, 64'(oValid), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    iRst = 1'b1; iStart = 1'b0; iKill = 1'b0; iSigned = 1'b0; iX = '0; iY = '0;
    repeat (3) @(posedge iClk);
    #1;
    check("rst_ready", 64'(oReady), 64'd1);
    check("rst_valid", 64'(oValid), 64'd0);
    check("rst_q", 64'(oQ), 64'd0);
    check("rst_r", 64'(oR), 64'd0);
    check("rst_flags", {62'd0, oDivZero, oOverflow}, 64'd0);
    @(negedge iClk); iRst = 1'b0;

    run_op("u100_7", 1'b0, 32'd100, 32'd7);
    run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    run_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    run_op("s_dz", 1'b1, 32'h1234, 32'd0);
    run_op("u_dz", 1'b0, 32'h1234, 32'd0);
    run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("u_ovf_ops", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);

    // Kill mid-CALC: no result, outputs untouched.
    @(negedge iClk);
    start_op(1'b0, 32'd1234, 32'd7);
    repeat (9) @(posedge iClk);
    @(negedge iClk); iKill = 1'b1;
    @(posedge iClk); #1;
    iKill = 1'b0;
    check("kill_ready", 64'(oReady), 64'd1);
    check("kill_valid", 64'(oValid), 64'd0);
    check("kill_q", 64'(oQ), 64'(last_q));
    check("kill_r", 64'(oR), 64'(last_r));
    begin
      int seen = 0;
      repeat (40) begin
        @(posedge iClk); #1;
        if (oValid) seen++;
      end
      check("kill_novalid", 64'(seen), 64'd0);
    end
    run_op("after_kill", 1'b0, 32'd50, 32'd5);

    // Stray start during CALC must be ignored.
    @(negedge iClk);
    start_op(1'b0, 32'd1000, 32'd3);
    wait_result("busy_start", 1'b0, 32'd1000, 32'd3, 5);
    @(posedge iClk); #1;
    check("busy_pulse", 64'(oValid), 64'd0);

    // Back-to-back: second request accepted in DONE.
    @(negedge iClk);
    start_op(1'b1, 32'hFFFF_FF00, 32'd9);
    wait_result("b2b_a", 1'b1, 32'hFFFF_FF00, 32'd9, -1);
    start_op(1'b0, 32'd123456, 32'd321);
    check("b2b_calc", 64'(oValid), 64'd0);
    wait_result("b2b_b", 1'b0, 32'd123456, 32'd321, -1);

    // Asynchronous reset mid-CALC.
    @(negedge iClk);
    start_op(1'b0, 32'd999, 32'd4);
    repeat (10) @(posedge iClk);
    @(negedge iClk); iRst = 1'b1;
    #1;
    check("arst_q", 64'(oQ), 64'd0);
    check("arst_r", 64'(oR), 64'd0);
    check("arst_valid", 64'(oValid), 64'd0);
    check("arst_ready", 64'(oReady), 64'd1);
    @(negedge iClk); iRst = 1'b0;
    run_op("after_rst", 1'b0, 32'd9, 32'd3);

    for (int i = 0; i < 40; i++) begin
      logic s;
      logic [W-1:0] x, y;
      int kind;
      s = 1'($urandom_range(0, 1));
      x = $urandom;
      y = $urandom;
      kind = $urandom_range(0, 9);
      if (kind == 0) y = '0;
      else if (kind == 1) begin s = 1'b1; x = 32'h8000_0000; y = '1; end
      else if (kind == 2) y = 32'($urandom_range(1, 15));
      else if (kind == 3) y = 32'hFFFF_FFFF;
      run_op($sformatf("rnd%0d", i), s, x, y);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
